// File: rtl/demux_1_to_3_reg_if.sv
// -----------------------------------------------------------------------------
// demux_1_to_3_reg_if
// Handshake bundle for the registered 1-to-3 demultiplexer.
//   d, s1, s0, in_valid, in_ready   : input word, port select, input handshake
//   u, v, w                         : buffered output words
//   u/v/w_valid, u/v/w_ready        : per-port output handshakes
//   cnt_u, cnt_v, cnt_w             : per-port delivery counters (wrapping)
// master = producer/consumer side (testbench / board), slave = demux block.
// -----------------------------------------------------------------------------
interface demux_1_to_3_reg_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] d;
    logic             s0;
    logic             s1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] w;
    logic             u_valid;
    logic             v_valid;
    logic             w_valid;
    logic             u_ready;
    logic             v_ready;
    logic             w_ready;
    logic [CNT_W-1:0] cnt_u;
    logic [CNT_W-1:0] cnt_v;
    logic [CNT_W-1:0] cnt_w;

    modport slave (
        input  d, s0, s1, in_valid, u_ready, v_ready, w_ready,
        output in_ready, u, v, w, u_valid, v_valid, w_valid,
               cnt_u, cnt_v, cnt_w
    );

    modport master (
        output d, s0, s1, in_valid, u_ready, v_ready, w_ready,
        input  in_ready, u, v, w, u_valid, v_valid, w_valid,
               cnt_u, cnt_v, cnt_w
    );
endinterface

// File: rtl/demux_1_to_3_reg.sv
// -----------------------------------------------------------------------------
// demux_1_to_3_reg
// Registered 1-to-3 demultiplexer. One word per valid/ready handshake is
// steered by s1/s0 into one of three single-entry buffers (u, v, w), each
// drained by its own valid/ready handshake. A wrapping counter per port
// counts delivered (drained) words.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : demux_1_to_3_reg_if.slave (see interface file for signal list)
// Select: s1=1 -> w, s1=0/s0=0 -> u, s1=0/s0=1 -> v.
//
// Per-port state table:
//   ST_EMPTY | buffer holds no word, x_valid = 0
//   ST_FULL  | buffer holds a word, x_valid = 1, data held stable
// -----------------------------------------------------------------------------
module demux_1_to_3_reg #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_1_to_3_reg_if.slave        bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } port_state_e;

    // Index 0 = u, 1 = v, 2 = w throughout.
    port_state_e      r_state     [3];
    port_state_e      w_state_nxt [3];
    logic [WIDTH-1:0] r_data      [3];
    logic [CNT_W-1:0] r_cnt       [3];

    logic [2:0] w_sel;
    logic [2:0] w_valid;
    logic [2:0] w_ready;
    logic [2:0] w_drain;
    logic [2:0] w_accept;
    logic       w_in_ready;

    always_comb begin
        w_sel   = {bus.s1, ~bus.s1 & bus.s0, ~bus.s1 & ~bus.s0};
        w_ready = {bus.w_ready, bus.v_ready, bus.u_ready};
        for (int i = 0; i < 3; i++) begin
            w_valid[i] = (r_state[i] == ST_FULL);
        end
        w_drain    = w_valid & w_ready;
        // Selected buffer can take a word if empty, or if it is being
        // drained this same cycle (pass-through refill). No in_valid term.
        w_in_ready = |(w_sel & (~w_valid | w_ready));
        w_accept   = w_sel & {3{bus.in_valid & w_in_ready}};
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_EMPTY: if (w_accept[i])                 w_state_nxt[i] = ST_FULL;
                ST_FULL:  if (w_drain[i] && !w_accept[i])  w_state_nxt[i] = ST_EMPTY;
                default:                                   w_state_nxt[i] = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= ST_EMPTY;
                r_data[i]  <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (w_accept[i]) begin
                    r_data[i] <= bus.d;
                end
                if (w_drain[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.u        = r_data[0];
    assign bus.v        = r_data[1];
    assign bus.w        = r_data[2];
    assign bus.u_valid  = w_valid[0];
    assign bus.v_valid  = w_valid[1];
    assign bus.w_valid  = w_valid[2];
    assign bus.cnt_u    = r_cnt[0];
    assign bus.cnt_v    = r_cnt[1];
    assign bus.cnt_w    = r_cnt[2];

endmodule

// File: tb/tb_demux_1_to_3_reg.sv
module tb_demux_1_to_3_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_1_to_3_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

    demux_1_to_3_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_in(input logic vld, input logic [1:0] sel, input logic [7:0] d);
        bus_if.in_valid = vld;
        bus_if.s1       = sel[1];
        bus_if.s0       = sel[0];
        bus_if.d        = d;
    endtask

    // rdy = {w, v, u}
    task automatic set_rdy(input logic [2:0] rdy);
        bus_if.u_ready = rdy[0];
        bus_if.v_ready = rdy[1];
        bus_if.w_ready = rdy[2];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       in_valid;
        logic [1:0] sel;
        logic [7:0] d;
        logic [2:0] rdy;         // {w,v,u}
        logic       exp_in_ready;
        logic [2:0] exp_valid;   // {w,v,u} after the edge
        logic [7:0] exp_u;
        logic [7:0] exp_v;
        logic [7:0] exp_w;
        logic [7:0] exp_cu;
        logic [7:0] exp_cv;
        logic [7:0] exp_cw;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Select decode with all readies high.
        vecs[0] = '{1'b1, 2'b00, 8'h11, 3'b111, 1'b1, 3'b001, 8'h11, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0};
        vecs[1] = '{1'b1, 2'b01, 8'h22, 3'b111, 1'b1, 3'b010, 8'h00, 8'h22, 8'h00, 8'd1, 8'd0, 8'd0};
        vecs[2] = '{1'b1, 2'b10, 8'h33, 3'b111, 1'b1, 3'b100, 8'h00, 8'h00, 8'h33, 8'd1, 8'd1, 8'd0};
        vecs[3] = '{1'b1, 2'b11, 8'h44, 3'b111, 1'b1, 3'b100, 8'h00, 8'h00, 8'h44, 8'd1, 8'd1, 8'd1};
        vecs[4] = '{1'b0, 2'b00, 8'h00, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 8'd1, 8'd1, 8'd2};

        set_in(1'b0, 2'b00, 8'h00);
        set_rdy(3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valids", {bus_if.w_valid, bus_if.v_valid, bus_if.u_valid}, 3'b000);
        chk("reset_data", {bus_if.u, bus_if.v, bus_if.w}, 24'h0);
        chk("reset_cnt", {bus_if.cnt_u, bus_if.cnt_v, bus_if.cnt_w}, 24'h0);
        chk("reset_in_ready", bus_if.in_ready, 1'b1);
        #3;
        rst = 1'b0;
        tick();

        // Table-driven select decode.
        for (int i = 0; i < 5; i++) begin
            set_in(vecs[i].in_valid, vecs[i].sel, vecs[i].d);
            set_rdy(vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), bus_if.in_ready, vecs[i].exp_in_ready);
            tick();
            chk($sformatf("vec%0d_valid", i), {bus_if.w_valid, bus_if.v_valid, bus_if.u_valid}, vecs[i].exp_valid);
            if (vecs[i].exp_valid[0]) chk($sformatf("vec%0d_u", i), bus_if.u, vecs[i].exp_u);
            if (vecs[i].exp_valid[1]) chk($sformatf("vec%0d_v", i), bus_if.v, vecs[i].exp_v);
            if (vecs[i].exp_valid[2]) chk($sformatf("vec%0d_w", i), bus_if.w, vecs[i].exp_w);
            chk($sformatf("vec%0d_cnt", i), {bus_if.cnt_u, bus_if.cnt_v, bus_if.cnt_w},
                {vecs[i].exp_cu, vecs[i].exp_cv, vecs[i].exp_cw});
        end

        // Backpressure on u.
        set_rdy(3'b000);
        set_in(1'b1, 2'b00, 8'hA5);
        #1;
        chk("bp_first_in_ready", bus_if.in_ready, 1'b1);
        tick();
        chk("bp_u_valid", bus_if.u_valid, 1'b1);
        chk("bp_u_data", bus_if.u, 8'hA5);
        set_in(1'b1, 2'b00, 8'h5A);
        #1;
        chk("bp_second_blocked", bus_if.in_ready, 1'b0);
        tick();
        chk("bp_u_hold", bus_if.u, 8'hA5);
        chk("bp_u_hold_valid", bus_if.u_valid, 1'b1);
        chk("bp_cnt_u_hold", bus_if.cnt_u, 8'd1);
        set_rdy(3'b001);
        #1;
        chk("bp_refill_in_ready", bus_if.in_ready, 1'b1);
        tick();
        chk("bp_refill_valid", bus_if.u_valid, 1'b1);
        chk("bp_refill_data", bus_if.u, 8'h5A);
        chk("bp_refill_cnt", bus_if.cnt_u, 8'd2);
        set_rdy(3'b000);

        // Independence: u blocked and full, v accepts.
        set_in(1'b1, 2'b01, 8'h77);
        #1;
        chk("ind_in_ready", bus_if.in_ready, 1'b1);
        tick();
        chk("ind_v", {bus_if.v_valid, bus_if.v}, {1'b1, 8'h77});
        chk("ind_u", {bus_if.u_valid, bus_if.u}, {1'b1, 8'h5A});
        chk("ind_cnt_u", bus_if.cnt_u, 8'd2);

        // Fill w, then simultaneous drains.
        set_in(1'b1, 2'b10, 8'h99);
        tick();
        chk("sim_all_full", {bus_if.w_valid, bus_if.v_valid, bus_if.u_valid}, 3'b111);
        set_in(1'b0, 2'b00, 8'h00);
        set_rdy(3'b111);
        tick();
        chk("sim_all_empty", {bus_if.w_valid, bus_if.v_valid, bus_if.u_valid}, 3'b000);
        chk("sim_cnt", {bus_if.cnt_u, bus_if.cnt_v, bus_if.cnt_w}, {8'd3, 8'd2, 8'd3});
        // Ready on empty ports must not count.
        tick();
        chk("idle_ready_cnt", {bus_if.cnt_u, bus_if.cnt_v, bus_if.cnt_w}, {8'd3, 8'd2, 8'd3});

        // Async reset mid-stream with u and w full.
        set_rdy(3'b000);
        set_in(1'b1, 2'b00, 8'hA1);
        tick();
        set_in(1'b1, 2'b10, 8'hB2);
        tick();
        chk("pre_rst_full", {bus_if.w_valid, bus_if.u_valid}, 2'b11);
        set_in(1'b1, 2'b00, 8'hC3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valids", {bus_if.w_valid, bus_if.v_valid, bus_if.u_valid}, 3'b000);
        chk("rst_data", {bus_if.u, bus_if.v, bus_if.w}, 24'h0);
        chk("rst_cnt", {bus_if.cnt_u, bus_if.cnt_v, bus_if.cnt_w}, 24'h0);
        chk("rst_in_ready", bus_if.in_ready, 1'b1);
        tick();
        chk("rst_no_accept", bus_if.u_valid, 1'b0);
        #3;
        rst = 1'b0;
        tick();
        chk("post_rst_accept", {bus_if.u_valid, bus_if.u}, {1'b1, 8'hC3});

        // Streaming 300 words to w.
        set_rdy(3'b100);
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, 2'b10, 8'(i));
            #1;
            chk($sformatf("stream_in_ready_%0d", i), bus_if.in_ready, 1'b1);
            tick();
            chk($sformatf("stream_w_%0d", i), {bus_if.w_valid, bus_if.w}, {1'b1, 8'(i)});
        end
        set_in(1'b0, 2'b00, 8'h00);
        tick();
        chk("stream_w_drained", bus_if.w_valid, 1'b0);
        chk("stream_cnt_w", bus_if.cnt_w, 8'd44);
        chk("stream_u_untouched", {bus_if.u_valid, bus_if.u, bus_if.cnt_u}, {1'b1, 8'hC3, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
